// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment display slice:
// conversion FSM states, ALU letter codes, active-low segment patterns.
package sevseg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } bcd_state_t;

   localparam logic [3:0] LTR_A = 4'hA;
   localparam logic [3:0] LTR_B = 4'hB;
   localparam logic [3:0] LTR_C = 4'hC;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int unsigned NUM_DIGITS = 4;

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   function automatic logic [6:0] letter_seg(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         LTR_A:   s = SEG_A;
         LTR_B:   s = SEG_B;
         LTR_C:   s = SEG_C;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// ALU-to-display bundle: value and letter code in, multiplexed display out.
interface seven_seg_scan_if;
   logic [7:0] result;
   logic [3:0] m_3;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;

   modport master (output result, output m_3, input seg, input an, input busy);
   modport slave  (input result, input m_3, output seg, output an, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: captures a changed value, runs 8 shift-add-3
// iterations, then commits hundreds/tens/units to the display registers.
module bin2bcd_seq
   import sevseg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] result,
   output logic       busy,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] units
);

   bcd_state_t  state;
   logic [7:0]  captured;
   logic [7:0]  shreg;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  iter;

   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         captured <= '0;
         shreg    <= '0;
         bcd      <= '0;
         iter     <= '0;
         busy     <= 1'b0;
         hundreds <= '0;
         tens     <= '0;
         units    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (result != captured) begin
                  captured <= result;
                  shreg    <= result;
                  bcd      <= '0;
                  iter     <= '0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               // Adjusted BCD and remaining binary bits shift as one word, MSB first.
               {bcd, shreg} <= {bcd_adj[10:0], shreg, 1'b0};
               iter         <= iter + 3'd1;
               if (iter == 3'd7)
                  state <= COMMIT;
            end
            COMMIT: begin
               hundreds <= bcd[11:8];
               tens     <= bcd[7:4];
               units    <= bcd[3:0];
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode scan driver: letter digit plus 000-255 decimal.
// Define SEVSEG_LZB_EN to blank leading zeros in hundreds/tens.
module seven_seg_scan
   import sevseg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   seven_seg_scan_if.slave  bus
);

   localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

   logic [3:0]    hundreds, tens, units;
   logic          busy;
   logic [3:0]    letter;
   logic [CW-1:0] refresh_cnt;
   logic [1:0]    scan_idx;
   logic [6:0]    hund_seg, tens_seg, slot_seg;
   logic [6:0]    seg_q;
   logic [3:0]    an_q;

   bin2bcd_seq u_bcd (
      .clk      (clk),
      .rst      (rst),
      .result   (bus.result),
      .busy     (busy),
      .hundreds (hundreds),
      .tens     (tens),
      .units    (units)
   );

   always_comb begin
      hund_seg = digit_seg(hundreds);
      tens_seg = digit_seg(tens);
`ifdef SEVSEG_LZB_EN
      if (hundreds == 4'd0)
         hund_seg = SEG_BLANK;
      if (hundreds == 4'd0 && tens == 4'd0)
         tens_seg = SEG_BLANK;
`endif
      case (scan_idx)
         2'd0:    slot_seg = digit_seg(units);
         2'd1:    slot_seg = tens_seg;
         2'd2:    slot_seg = hund_seg;
         default: slot_seg = letter_seg(letter);
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         letter      <= '0;
         refresh_cnt <= '0;
         scan_idx    <= '0;
         seg_q       <= SEG_BLANK;
         an_q        <= '1;
      end else begin
         letter <= bus.m_3;
         if (refresh_cnt == TERM) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
         // Anode and pattern come from the same index on the same edge.
         seg_q <= slot_seg;
         an_q  <= ~(4'b0001 << scan_idx);
      end
   end

   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
   assign bus.busy = busy;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan with REFRESH_DIV=4.
module tb_seven_seg_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seven_seg_scan_if bus ();

   seven_seg_scan #(.REFRESH_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef SEVSEG_LZB_EN
   localparam logic [6:0] EXP_LZ_H = 7'h7F;
   localparam logic [6:0] EXP_LZ_T = 7'h7F;
`else
   localparam logic [6:0] EXP_LZ_H = 7'h40;
   localparam logic [6:0] EXP_LZ_T = 7'h40;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits for a fresh entry into the given slot, then checks its pattern.
   task automatic check_slot(input string tag, input logic [1:0] slot, input logic [6:0] exp);
      logic [3:0] one;
      logic [3:0] tgt;
      int n;
      one = 4'b0001;
      tgt = ~(one << slot);
      n = 0;
      while (bus.an == tgt && n < 40) begin @(negedge clk); n++; end
      while (bus.an != tgt && n < 40) begin @(negedge clk); n++; end
      chk({tag, "_an"}, {28'd0, bus.an}, {28'd0, tgt});
      chk(tag, {25'd0, bus.seg}, {25'd0, exp});
   endtask

   task automatic wait_busy_fall();
      int n;
      n = 0;
      while (bus.busy && n < 30) begin @(negedge clk); n++; end
      chk("busy_fall_timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      int n;
      logic [3:0] prev;

      bus.result = 8'd0;
      bus.m_3    = 4'h0;

      // Reset values, asynchronous
      #2 rst = 1'b0;
      #1;
      chk("rst_seg",  {25'd0, bus.seg}, 32'h7F);
      chk("rst_an",   {28'd0, bus.an},  32'hF);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick(5);
      chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      check_slot("rst_units", 2'd0, 7'h40);
      check_slot("rst_letter", 2'd3, 7'h7F);

      // Max value: busy for exactly 9 cycles
      bus.result = 8'd255;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.busy) n++;
      end
      chk("busy_len_255", n, 32'd9);
      check_slot("d255_h", 2'd2, 7'h24);
      check_slot("d255_t", 2'd1, 7'h12);
      check_slot("d255_u", 2'd0, 7'h12);

      // Letter digit
      bus.m_3 = 4'hB;
      check_slot("ltr_b", 2'd3, 7'h03);
      bus.m_3 = 4'hA;
      check_slot("ltr_a", 2'd3, 7'h08);
      bus.m_3 = 4'hC;
      check_slot("ltr_c", 2'd3, 7'h46);
      bus.m_3 = 4'h3;
      check_slot("ltr_3", 2'd3, 7'h7F);

      // Change mid-conversion
      bus.result = 8'd100;
      tick(3);
      bus.result = 8'd37;
      tick(1);
      wait_busy_fall();
      chk("mid1_h", {28'd0, dut.u_bcd.hundreds}, 32'd1);
      chk("mid1_t", {28'd0, dut.u_bcd.tens},     32'd0);
      chk("mid1_u", {28'd0, dut.u_bcd.units},    32'd0);
      @(negedge clk);
      chk("mid_restart_busy", {31'd0, bus.busy}, 32'd1);
      wait_busy_fall();
      chk("mid2_h", {28'd0, dut.u_bcd.hundreds}, 32'd0);
      chk("mid2_t", {28'd0, dut.u_bcd.tens},     32'd3);
      chk("mid2_u", {28'd0, dut.u_bcd.units},    32'd7);
      check_slot("d37_u", 2'd0, 7'h78);
      check_slot("d37_t", 2'd1, 7'h30);
      check_slot("d37_h", 2'd2, EXP_LZ_H);

      // Leading zeros
      bus.result = 8'd7;
      tick(1);
      wait_busy_fall();
      check_slot("d7_h", 2'd2, EXP_LZ_H);
      check_slot("d7_t", 2'd1, EXP_LZ_T);
      check_slot("d7_u", 2'd0, 7'h78);

      // Reset during SHIFT iteration 4
      bus.result = 8'd200;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      chk("shift_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_seg",  {25'd0, bus.seg}, 32'h7F);
      chk("midrst_an",   {28'd0, bus.an},  32'hF);
      chk("midrst_h",    {28'd0, dut.u_bcd.hundreds}, 32'd0);
      bus.result = 8'd0;
      @(negedge clk);
      rst = 1'b1;
      tick(12);
      chk("after_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("after_rst_t", {28'd0, dut.u_bcd.tens},  32'd0);
      chk("after_rst_u", {28'd0, dut.u_bcd.units}, 32'd0);

      // Scan slot length and frame wrap
      check_slot("wrap_units", 2'd0, 7'h40);
      n = 0;
      while (bus.an == 4'b1110 && n < 40) begin @(negedge clk); n++; end
      chk("slot0_len", n, 32'd4);
      prev = bus.an;
      while (bus.an != 4'b1110 && n < 40) begin prev = bus.an; @(negedge clk); n++; end
      chk("frame_len", n, 32'd16);
      chk("wrap_from_3", {28'd0, prev}, 32'h7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
